multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV64 datapath (PC, RegFile, ALU, ImmGen, unified instruction/data memory).
- Replaces per-instruction single-cycle decode. Each instruction is sequenced over 3–5+ cycles through a single shared memory port with a req/ready handshake.
- Drives all datapath enables and muxes, and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the performance counters (used only with MCTRL_PERF_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state to IDLE.
- run  in  1  level; permits starting a new instruction.
- opcode  in  7  instruction register bits [6:0].
- alu_zero  in  1  ALU zero flag (branch compare result).
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write qualifier for mem_req.
- mem_src_inst  out  1  memory address mux: 1 = PC, 0 = ALU result.
- ir_write  out  1  load instruction register from memory read data.
- pc_write  out  1  PC <= PC+4.
- pc_branch  out  1  PC <= branch target (supplied by the datapath from the latched PC of this instruction).
- alu_src_b  out  1  ALU operand B: 1 = immediate, 0 = rs2.
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- reg_write  out  1  RegFile write enable.
- mem_to_reg  out  1  write-back mux: 1 = memory data, 0 = ALU result.
- retire  out  1  one-cycle pulse on an instruction's final cycle.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state encoding, for debug.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM_RD=4, MEM_WR=5, WB_ALU=6, WB_MEM=7, BRANCH=8. Encodings 9–15 recover to IDLE on the next clock.
- Reset (async): state=IDLE. All outputs are 0 while in IDLE.
- Outputs are decoded from state, except pc_branch, ir_write, pc_write and retire, which also depend on alu_zero / mem_ready.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH:
  - mem_req=1, mem_src_inst=1, mem_we=0.
  - mem_ready=1 -> ir_write=1, pc_write=1, go to DECODE.
  - Otherwise hold all outputs and stay.
  - run is ignored once in FETCH; a request is never withdrawn.
- DECODE: next state by opcode:
  - 0110011 or 0010011 -> EXEC.
  - 0000011 or 0100011 -> EXEC.
  - 1100011 -> BRANCH.
  - Any other value -> illegal=1 for this cycle, then IDLE; no retire, no register or memory write.
- EXEC:
  - R-type (0110011): alu_src_b=0, alu_op=10.
  - I-type ALU (0010011): alu_src_b=1, alu_op=10.
  - Load/store: alu_src_b=1, alu_op=00.
  - Next state: R/I -> WB_ALU; load -> MEM_RD; store -> MEM_WR.
  - Opcode is held stable by the IR, which is written only in FETCH.
- MEM_RD:
  - mem_req=1, mem_src_inst=0, alu_op=00, alu_src_b=1 (address held stable).
  - Go to WB_MEM on mem_ready.
- MEM_WR:
  - Same drive as MEM_RD plus mem_we=1.
  - On mem_ready: retire=1, next state = FETCH if run else IDLE.
- WB_ALU: reg_write=1, mem_to_reg=0, ALU controls as in EXEC; retire=1; next state = FETCH if run else IDLE.
- WB_MEM: reg_write=1, mem_to_reg=1; retire=1; next state = FETCH if run else IDLE.
- BRANCH:
  - alu_src_b=0, alu_op=01, pc_branch=alu_zero (BEQ semantics), retire=1.
  - Next state = FETCH if run else IDLE.
- Latency with mem_ready tied high: ALU instruction 4 cycles, load 5, store 4, branch 3.
- Each wait cycle on mem_ready adds one cycle to the fetch or memory stage.
- Simultaneous events:
  - pc_write and pc_branch are never both 1.
  - reg_write and mem_req are never both 1.
  - mem_we=1 only when mem_req=1.
- Reset mid-transaction: request dropped immediately (async). Memory must tolerate an abandoned request.

Optional Feature:
- Macro: MCTRL_PERF_EN.
- When defined, adds two outputs: cycle_cnt [CNT_W] and instret_cnt [CNT_W].
  - cycle_cnt increments every clock when state != IDLE.
  - instret_cnt increments on each retire pulse.
  - Both wrap modulo 2^CNT_W and clear on reset.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset asserted mid-FETCH with mem_req=1 -> same-cycle state=0, mem_req=0; outputs stay 0 with run=0.
- run=1, mem_ready=1, opcode=0110011 -> states 1,2,3,6,1; reg_write only in cycle 4; retire pulse in cycle 4.
- Load opcode 0000011, mem_ready low for 2 cycles in MEM_RD -> mem_req held 3 cycles, address mux=0, WB_MEM follows, total 7 cycles.
- Store 0100011 -> mem_we=1 only in MEM_WR; no reg_write; retire on the mem_ready cycle.
- Branch 1100011: alu_zero=1 -> pc_branch=1 in BRANCH; alu_zero=0 -> pc_branch=0; 3 cycles each.
- Opcode 1111111 -> illegal pulse in DECODE, return to IDLE, no retire; with MCTRL_PERF_EN, instret_cnt unchanged and cycle_cnt += 2.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV64 datapath: sequences fetch/decode/execute/memory/write-back
// over one shared memory port. Define MCTRL_PERF_EN to add cycle and retired-instruction counters.
module multicycle_ctrl
`ifdef MCTRL_PERF_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_src_inst,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_branch,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             retire,
    output logic             illegal,
`ifdef MCTRL_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
`endif
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_ALU = 4'd6,
        S_WB_MEM = 4'd7,
        S_BRANCH = 4'd8
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    state_t cur_state;
    state_t nxt_state;

    logic is_r, is_i, is_ld, is_st, is_br;

    assign is_r  = (opcode == OP_R);
    assign is_i  = (opcode == OP_I);
    assign is_ld = (opcode == OP_LOAD);
    assign is_st = (opcode == OP_STORE);
    assign is_br = (opcode == OP_BRANCH);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= S_IDLE;
        else       cur_state <= nxt_state;
    end

    assign state = cur_state;

    // NOTE: every signal driven here gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        nxt_state    = cur_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_src_inst = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_branch    = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        retire       = 1'b0;
        illegal      = 1'b0;

        case (cur_state)
            S_IDLE: begin
                if (run) nxt_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_src_inst = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_r || is_i || is_ld || is_st) nxt_state = S_EXEC;
                else if (is_br)                     nxt_state = S_BRANCH;
                else begin
                    illegal   = 1'b1;
                    nxt_state = S_IDLE;
                end
            end
            S_EXEC: begin
                // IR is stable here, so the opcode class seen in DECODE still holds.
                alu_src_b = !is_r;
                alu_op    = (is_r || is_i) ? ALU_FUNCT : ALU_ADD;
                if (is_r || is_i) nxt_state = S_WB_ALU;
                else if (is_ld)   nxt_state = S_MEM_RD;
                else if (is_st)   nxt_state = S_MEM_WR;
                else              nxt_state = S_IDLE;
            end
            S_MEM_RD: begin
                mem_req   = 1'b1;
                alu_src_b = 1'b1;
                if (mem_ready) nxt_state = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                alu_src_b = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    nxt_state = run ? S_FETCH : S_IDLE;
                end
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                alu_src_b = is_i;
                alu_op    = ALU_FUNCT;
                retire    = 1'b1;
                nxt_state = run ? S_FETCH : S_IDLE;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                nxt_state  = run ? S_FETCH : S_IDLE;
            end
            S_BRANCH: begin
                alu_op    = ALU_SUB;
                pc_branch = alu_zero;
                retire    = 1'b1;
                nxt_state = run ? S_FETCH : S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

`ifdef MCTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (cur_state != S_IDLE) cycle_cnt   <= cycle_cnt + CNT_W'(1);
            if (retire)              instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle stimulus with hand-written expected
// control vectors queued as a scoreboard and compared at the falling edge.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       mem_src_inst;
        logic       ir_write;
        logic       pc_write;
        logic       pc_branch;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       retire;
        logic       illegal;
    } outs_t;

    typedef struct {
        string      tag;
        logic       run;
        logic       mem_ready;
        logic       alu_zero;
        logic [6:0] opcode;
        outs_t      exp;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [6:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_src_inst, ir_write, pc_write, pc_branch;
    logic       alu_src_b, reg_write, mem_to_reg, retire, illegal;
    logic [1:0] alu_op;
    logic [3:0] state;
`ifdef MCTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
    int unsigned model_cycles = 0;
    int unsigned model_instret = 0;
`endif

    int checks = 0;
    int errors = 0;
    int seq_n  = 0;
    cyc_t  stim_q[$];
    outs_t exp_q[$];

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_src_inst(mem_src_inst), .ir_write(ir_write), .pc_write(pc_write),
        .pc_branch(pc_branch), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
        .illegal(illegal),
`ifdef MCTRL_PERF_EN
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic outs_t observed();
        outs_t o;
        o = '{state, mem_req, mem_we, mem_src_inst, ir_write, pc_write, pc_branch,
              alu_src_b, alu_op, reg_write, mem_to_reg, retire, illegal};
        return o;
    endfunction

    // Expected control vector for each named cycle kind, written out by hand.
    function automatic outs_t exp_out(input string kind);
        outs_t o;
        o = '0;
        case (kind)
            "idle":       ;
            "fetch_wait": begin o.state = 4'd1; o.mem_req = 1; o.mem_src_inst = 1; end
            "fetch":      begin o.state = 4'd1; o.mem_req = 1; o.mem_src_inst = 1;
                                o.ir_write = 1; o.pc_write = 1; end
            "decode":     o.state = 4'd2;
            "illegal":    begin o.state = 4'd2; o.illegal = 1; end
            "exec_r":     begin o.state = 4'd3; o.alu_op = 2'b10; end
            "exec_i":     begin o.state = 4'd3; o.alu_op = 2'b10; o.alu_src_b = 1; end
            "exec_ls":    begin o.state = 4'd3; o.alu_src_b = 1; end
            "rd":         begin o.state = 4'd4; o.mem_req = 1; o.alu_src_b = 1; end
            "wr_wait":    begin o.state = 4'd5; o.mem_req = 1; o.mem_we = 1; o.alu_src_b = 1; end
            "wr":         begin o.state = 4'd5; o.mem_req = 1; o.mem_we = 1; o.alu_src_b = 1;
                                o.retire = 1; end
            "wb_r":       begin o.state = 4'd6; o.reg_write = 1; o.alu_op = 2'b10; o.retire = 1; end
            "wb_i":       begin o.state = 4'd6; o.reg_write = 1; o.alu_op = 2'b10;
                                o.alu_src_b = 1; o.retire = 1; end
            "wb_mem":     begin o.state = 4'd7; o.reg_write = 1; o.mem_to_reg = 1; o.retire = 1; end
            "br_t":       begin o.state = 4'd8; o.alu_op = 2'b01; o.pc_branch = 1; o.retire = 1; end
            "br_n":       begin o.state = 4'd8; o.alu_op = 2'b01; o.retire = 1; end
            default:      o = '1;
        endcase
        return o;
    endfunction

    task automatic push(input string kind, input logic r, input logic rdy, input logic az,
                        input logic [6:0] opc);
        cyc_t c;
        c.tag = $sformatf("%s#%0d", kind, seq_n);
        c.run = r; c.mem_ready = rdy; c.alu_zero = az; c.opcode = opc;
        c.exp = exp_out(kind);
        stim_q.push_back(c);
        seq_n++;
    endtask

    // Drives one queued cycle at a time (inputs just after the rising edge), compares at the falling edge.
    task automatic run_stim();
        cyc_t  c;
        outs_t e;
        outs_t got;
        while (stim_q.size() > 0) begin
            c = stim_q.pop_front();
            run = c.run; mem_ready = c.mem_ready; alu_zero = c.alu_zero; opcode = c.opcode;
            exp_q.push_back(c.exp);
            @(negedge clk);
            e   = exp_q.pop_front();
            got = observed();
            check(c.tag, 32'(got), 32'(e));
            check({c.tag, "_pcw_pcb"}, 32'(pc_write & pc_branch), 32'd0);
            check({c.tag, "_rw_req"},  32'(reg_write & mem_req), 32'd0);
            check({c.tag, "_we_req"},  32'(mem_we & ~mem_req), 32'd0);
`ifdef MCTRL_PERF_EN
            check({c.tag, "_cyc"}, cycle_cnt, model_cycles);
            check({c.tag, "_ret"}, instret_cnt, model_instret);
`endif
            @(posedge clk);
`ifdef MCTRL_PERF_EN
            if (e.state != 4'd0) model_cycles++;
            if (e.retire)        model_instret++;
`endif
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; opcode = '0; alu_zero = 1'b0; mem_ready = 1'b0;
        #2;
        check("reset_state", 32'(observed()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Idle holds with run low; then start a fetch that stalls and is cut by async reset.
        push("idle", 0, 1, 0, OP_R);
        push("idle", 0, 1, 0, OP_R);
        push("idle", 1, 0, 0, OP_R);
        push("fetch_wait", 1, 0, 0, OP_R);
        run_stim();
        check("mid_fetch_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_state", 32'(state), 32'd0);
        check("rst_async_req", 32'(mem_req), 32'd0);
`ifdef MCTRL_PERF_EN
        model_cycles = 0; model_instret = 0;
`endif
        @(posedge clk); #1;
        run = 1'b0;
        reset = 1'b0;
        push("idle", 0, 1, 0, OP_R);
        push("idle", 0, 1, 0, OP_R);
        run_stim();

        // R-type then back-to-back I-type with run held high.
        push("idle",   1, 1, 0, OP_R);
        push("fetch",  1, 1, 0, OP_R);
        push("decode", 1, 1, 0, OP_R);
        push("exec_r", 1, 1, 0, OP_R);
        push("wb_r",   1, 1, 0, OP_R);
        push("fetch",  1, 1, 0, OP_I);
        push("decode", 1, 1, 0, OP_I);
        push("exec_i", 1, 1, 0, OP_I);
        push("wb_i",   0, 1, 0, OP_I);
        push("idle",   1, 1, 0, OP_LD);

        // Load: one fetch wait, two memory waits.
        push("fetch_wait", 0, 0, 0, OP_LD);
        push("fetch",      0, 1, 0, OP_LD);
        push("decode",     0, 1, 0, OP_LD);
        push("exec_ls",    0, 1, 0, OP_LD);
        push("rd",         0, 0, 0, OP_LD);
        push("rd",         0, 0, 0, OP_LD);
        push("rd",         0, 1, 0, OP_LD);
        push("wb_mem",     0, 1, 0, OP_LD);
        push("idle",       1, 1, 0, OP_ST);

        // Store with one write wait; continues straight into a taken branch.
        push("fetch",   1, 1, 1, OP_ST);
        push("decode",  1, 1, 1, OP_ST);
        push("exec_ls", 1, 1, 1, OP_ST);
        push("wr_wait", 1, 0, 1, OP_ST);
        push("wr",      1, 1, 1, OP_ST);
        push("fetch",   1, 1, 1, OP_BR);
        push("decode",  1, 1, 1, OP_BR);
        push("br_t",    1, 1, 1, OP_BR);
        push("fetch",   1, 1, 1, OP_BR);
        push("decode",  1, 1, 1, OP_BR);
        push("br_n",    1, 1, 0, OP_BR);

        // Illegal opcode returns to IDLE even with run high, without retiring.
        push("fetch",   1, 1, 0, OP_BAD);
        push("illegal", 1, 1, 0, OP_BAD);
        push("idle",    0, 1, 0, OP_BAD);
        push("idle",    0, 1, 0, OP_BAD);
        run_stim();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
